// File: rtl/obstacle_scheduler.sv
// Game-phase sequencer: alternates gap/run intervals per obstacle off the vsync frame tick,
// drives the obstacle mux select, and turns raw collision levels into qualified hit pulses.
module obstacle_scheduler #(
    parameter int NUM_OBSTACLES = 2,
    parameter int RUN_FRAMES    = 600,
    parameter int GAP_FRAMES    = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       play_selected,
    input  logic       game_over,
    input  logic       damage_in,
    output logic [3:0] obstacle_select,
    output logic       obstacle_active,
    output logic       obstacle_start,
    output logic       player_hit,
    output logic [7:0] round_count
);

    localparam logic [15:0] GAP_LAST    = 16'(GAP_FRAMES - 1);
    localparam logic [15:0] RUN_LAST    = 16'(RUN_FRAMES - 1);
    localparam logic [15:0] INVULN_LOAD = 16'(INVULN_FRAMES);
    localparam logic [3:0]  SEL_LAST    = 4'(NUM_OBSTACLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        RUN,
        OVER
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [15:0] invuln_cnt_reg, invuln_cnt_next;
    logic [3:0]  sel_reg, sel_next;
    logic [7:0]  round_reg, round_next;
    logic        start_reg, start_next;
    logic        hit_reg, hit_next;
    logic        active_reg, active_next;
    logic        vsync_prev_reg;
    logic        dmg_prev_reg;

    logic frame_tick;
    logic dmg_edge;

    // Edge detectors start "high" so a level already asserted at reset release is not an edge.
    assign frame_tick = vsync_in & ~vsync_prev_reg;
    assign dmg_edge   = damage_in & ~dmg_prev_reg;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            invuln_cnt_reg <= '0;
            sel_reg        <= '0;
            round_reg      <= '0;
            start_reg      <= 1'b0;
            hit_reg        <= 1'b0;
            active_reg     <= 1'b0;
            vsync_prev_reg <= 1'b1;
            dmg_prev_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            invuln_cnt_reg <= invuln_cnt_next;
            sel_reg        <= sel_next;
            round_reg      <= round_next;
            start_reg      <= start_next;
            hit_reg        <= hit_next;
            active_reg     <= active_next;
            vsync_prev_reg <= vsync_in;
            dmg_prev_reg   <= damage_in;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_cnt_next  = frame_cnt_reg;
        sel_next        = sel_reg;
        round_next      = round_reg;
        start_next      = 1'b0;
        hit_next        = 1'b0;
        invuln_cnt_next = invuln_cnt_reg;
        if (frame_tick && (invuln_cnt_reg != 16'd0)) begin
            invuln_cnt_next = invuln_cnt_reg - 16'd1;
        end

        case (state_reg)
            IDLE: begin
                frame_cnt_next = '0;
                sel_next       = '0;
                if (!game_over && play_selected) begin
                    state_next = GAP;
                    round_next = '0;
                end
            end

            GAP: begin
                if (game_over) begin
                    state_next = OVER;
                end else if (!play_selected) begin
                    state_next      = IDLE;
                    sel_next        = '0;
                    frame_cnt_next  = '0;
                    invuln_cnt_next = '0;
                end else if (frame_tick) begin
                    if (frame_cnt_reg == GAP_LAST) begin
                        state_next     = RUN;
                        frame_cnt_next = '0;
                        start_next     = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end
                end
            end

            RUN: begin
                if (game_over) begin
                    state_next = OVER;
                end else if (!play_selected) begin
                    state_next      = IDLE;
                    sel_next        = '0;
                    frame_cnt_next  = '0;
                    invuln_cnt_next = '0;
                end else begin
                    // A hit is independent of the run ending in the same cycle.
                    if (dmg_edge && (invuln_cnt_reg == 16'd0)) begin
                        hit_next        = 1'b1;
                        invuln_cnt_next = INVULN_LOAD;
                    end
                    if (frame_tick) begin
                        if (frame_cnt_reg == RUN_LAST) begin
                            state_next     = GAP;
                            frame_cnt_next = '0;
                            if (sel_reg == SEL_LAST) begin
                                sel_next = '0;
                                if (round_reg != 8'hFF) begin
                                    round_next = round_reg + 8'd1;
                                end
                            end else begin
                                sel_next = sel_reg + 4'd1;
                            end
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 16'd1;
                        end
                    end
                end
            end

            OVER: begin
                if (!play_selected) begin
                    state_next      = IDLE;
                    sel_next        = '0;
                    frame_cnt_next  = '0;
                    invuln_cnt_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        active_next = (state_next == RUN);
    end

    assign obstacle_select = sel_reg;
    assign obstacle_active = active_reg;
    assign obstacle_start  = start_reg;
    assign player_hit      = hit_reg;
    assign round_count     = round_reg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: expected start/hit pulses are queued by the stimulus
// and matched by an independent monitor; level outputs are checked at fixed points.
module tb_obstacle_scheduler;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vsync_in;
    logic       play_selected;
    logic       game_over;
    logic       damage_in;
    logic [3:0] obstacle_select;
    logic       obstacle_active;
    logic       obstacle_start;
    logic       player_hit;
    logic [7:0] round_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       is_hit;
        logic [3:0] sel;
        logic [7:0] round;
    } ev_t;

    ev_t exp_q[$];

    obstacle_scheduler #(
        .NUM_OBSTACLES(2),
        .RUN_FRAMES   (3),
        .GAP_FRAMES   (2),
        .INVULN_FRAMES(2)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .vsync_in       (vsync_in),
        .play_selected  (play_selected),
        .game_over      (game_over),
        .damage_in      (damage_in),
        .obstacle_select(obstacle_select),
        .obstacle_active(obstacle_active),
        .obstacle_start (obstacle_start),
        .player_hit     (player_hit),
        .round_count    (round_count)
    );

    always #5 pclk = ~pclk;

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1;
            step(2);
            vsync_in = 1'b0;
            step(2);
        end
    endtask

    task automatic damage_pulse();
        damage_in = 1'b1;
        step(2);
        damage_in = 1'b0;
        step(2);
    endtask

    task automatic expect_start(input logic [3:0] sel, input logic [7:0] round);
        exp_q.push_back('{is_hit: 1'b0, sel: sel, round: round});
    endtask

    task automatic expect_hit(input logic [3:0] sel, input logic [7:0] round);
        exp_q.push_back('{is_hit: 1'b1, sel: sel, round: round});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_levels(input string name, input logic active, input logic [3:0] sel,
                                input logic [7:0] round);
        check({name, "_active"}, 32'(obstacle_active), 32'(active));
        check({name, "_select"}, 32'(obstacle_select), 32'(sel));
        check({name, "_round"}, 32'(round_count), 32'(round));
    endtask

    // Monitor: every pulse the DUT presents must match the oldest queued expectation.
    task automatic match_event(input logic is_hit);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got pulse sel=%0d round=%0d, required none at %0t",
                     is_hit ? "hit" : "start", obstacle_select, round_count, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.is_hit !== is_hit || e.sel !== obstacle_select || e.round !== round_count) begin
                n_fail++;
                $display("FAIL event: got hit=%0d sel=%0d round=%0d, required hit=%0d sel=%0d round=%0d at %0t",
                         is_hit, obstacle_select, round_count, e.is_hit, e.sel, e.round, $time);
            end else begin
                $display("ok   %s pulse sel=%0d round=%0d", is_hit ? "hit" : "start",
                         obstacle_select, round_count);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            if (obstacle_start === 1'b1) match_event(1'b0);
            if (player_hit === 1'b1) match_event(1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        vsync_in      = 1'b1;
        play_selected = 1'b0;
        game_over     = 1'b0;
        damage_in     = 1'b0;
        step(3);

        // 1: release reset with vsync held high
        rst = 1'b0;
        step(2);
        vsync_in = 1'b0;
        step(2);
        check_levels("reset", 1'b0, 4'd0, 8'd0);
        check("reset_start", 32'(obstacle_start), 32'd0);
        check("reset_hit", 32'(player_hit), 32'd0);

        // 2: sequencing through both obstacles and one wrap
        play_selected = 1'b1;
        step(2);
        expect_start(4'd0, 8'd0);
        frames(2);
        check_levels("run0", 1'b1, 4'd0, 8'd0);
        frames(3);
        check_levels("gap1", 1'b0, 4'd1, 8'd0);
        expect_start(4'd1, 8'd0);
        frames(2);
        check_levels("run1", 1'b1, 4'd1, 8'd0);
        frames(3);
        check_levels("wrap1", 1'b0, 4'd0, 8'd1);
        expect_start(4'd0, 8'd1);
        frames(2);

        // 3: held damage gives one hit; re-hit inside invulnerability is dropped
        expect_hit(4'd0, 8'd1);
        damage_in = 1'b1;
        step(2);
        expect_start(4'd1, 8'd1);
        frames(5);
        damage_in = 1'b0;
        step(2);
        check_levels("run1b", 1'b1, 4'd1, 8'd1);
        expect_hit(4'd1, 8'd1);
        damage_pulse();
        frames(1);
        damage_pulse();
        frames(1);
        expect_hit(4'd1, 8'd1);
        damage_pulse();
        frames(1);
        check_levels("wrap2", 1'b0, 4'd0, 8'd2);

        // 4: damage edge in GAP is discarded and does not load invulnerability
        frames(1);
        damage_pulse();
        expect_start(4'd0, 8'd2);
        frames(1);
        expect_hit(4'd0, 8'd2);
        damage_pulse();

        // 5: game over freezes, play drop returns to IDLE, new game clears rounds
        frames(3);
        expect_start(4'd1, 8'd2);
        frames(2);
        frames(1);
        game_over = 1'b1;
        step(1);
        check_levels("over", 1'b0, 4'd1, 8'd2);
        frames(4);
        damage_pulse();
        check_levels("over_frozen", 1'b0, 4'd1, 8'd2);
        check("over_queue_empty", 32'(exp_q.size()), 32'd0);
        play_selected = 1'b0;
        step(1);
        check_levels("idle_after_over", 1'b0, 4'd0, 8'd2);
        game_over     = 1'b0;
        play_selected = 1'b1;
        step(1);
        check_levels("new_game", 1'b0, 4'd0, 8'd0);
        expect_start(4'd0, 8'd0);
        frames(2);
        check_levels("new_run", 1'b1, 4'd0, 8'd0);

        // 6: reset mid-RUN at counter 2 coinciding with a frame tick
        frames(2);
        rst      = 1'b1;
        vsync_in = 1'b1;
        step(1);
        check_levels("midrst", 1'b0, 4'd0, 8'd0);
        check("midrst_start", 32'(obstacle_start), 32'd0);
        check("midrst_hit", 32'(player_hit), 32'd0);
        rst = 1'b0;
        step(1);
        vsync_in = 1'b0;
        step(2);

        // round counter saturation across 257 full passes
        for (int r = 0; r < 257; r++) begin
            for (int idx = 0; idx < 2; idx++) begin
                expect_start(4'(idx), (r > 255) ? 8'd255 : 8'(r));
                frames(2);
                frames(3);
            end
            if (r == 254) check_levels("round_255", 1'b0, 4'd0, 8'd255);
        end
        check_levels("round_sat", 1'b0, 4'd0, 8'd255);

        step(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
